// File: rtl/cache_pkg.sv
// Shared definitions for the cache access controller.
//   state_e     : controller FSM states (IDLE, WRITE, READ, RESP)
//   DEF_ADDR_W  : default request/memory address width
//   DEF_DATA_W  : default data width
//   RD_LAT_MAX  : largest supported read latency (fits the 4-bit counter)
//   CNT_W       : width of the read-latency down-counter
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/cache_lat_counter.sv
// Read-phase latency down-counter.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i (takes priority over en_i)
//   load_val_i : value to load (RD_LAT-1)
//   en_i       : counting enabled (controller is in READ)
//   done_o     : combinational pulse while enabled and the count is zero
module cache_lat_counter
    import cache_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cache_access_ctrl.sv
// Cache access controller: accepts one core request at a time, drives a
// single-port cache memory (one write cycle, or RD_LAT read cycles) and
// returns a response held until the core takes it.
// Optional feature macro: CACHE_ACCESS_CTRL_ALIGN_CHECK_EN -- when defined,
// requests with req_addr[1:0] != 0 go straight to an error response.
// Ports:
//   clk, rst                      : clock / synchronous active-high reset
//   req_valid/req_ready           : request handshake (req_we, req_addr, req_wdata)
//   rsp_valid/rsp_ready           : response handshake (rsp_rdata, rsp_err)
//   mem_address, mem_write_data   : registered request address/data
//   mem_write_enable/read_enable  : memory strobes (never both high)
//   mem_read_data                 : memory read data
//   dbg_state                     : current FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and payload stable until then.
module cache_access_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output state_e            dbg_state
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              misaligned;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_done;

`ifdef CACHE_ACCESS_CTRL_ALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && req_valid;

    cache_lat_counter u_lat_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .en_i       (cnt_en),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        cnt_load         = 1'b0;
        cnt_en           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_load = 1'b1;
                    if (misaligned)  state_d = ST_RESP;
                    else if (req_we) state_d = ST_WRITE;
                    else             state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                mem_write_enable = 1'b1;
                state_d          = ST_RESP;
            end
            ST_READ: begin
                mem_read_enable = 1'b1;
                cnt_en          = 1'b1;
                if (cnt_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                // Writes and errors report zero read data.
                rdata_q <= '0;
                err_q   <= misaligned;
            end else if ((state_q == ST_READ) && cnt_done) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_cache_access_ctrl.sv
module tb_cache_access_ctrl;
    import cache_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_write_enable, mem_read_enable;
    state_e        dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .dbg_state(dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; mem_read_data = '0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready actual=%0h required=1", req_ready); end
        checks++;
        if ({rsp_valid, rsp_err, mem_write_enable, mem_read_enable} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags actual=%b required=0000", {rsp_valid, rsp_err, mem_write_enable, mem_read_enable});
        end
        checks++;
        if ({rsp_rdata, mem_address, mem_write_data} !== 96'd0) begin
            failures++; $display("FAIL reset_data rdata=%0h addr=%0h wdata=%0h required=0", rsp_rdata, mem_address, mem_write_data);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state actual=%0d required=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_write();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        step();  // acceptance edge -> WRITE
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h1234_5678;
        checks++;
        if ({mem_write_enable, mem_read_enable, rsp_valid, req_ready} !== 4'b1000) begin
            failures++; $display("FAIL write_strobe actual=%b required=1000", {mem_write_enable, mem_read_enable, rsp_valid, req_ready});
        end
        checks++;
        if (mem_address !== 32'h10 || mem_write_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL write_addr_data addr=%0h data=%0h required 10/deadbeef", mem_address, mem_write_data);
        end
        step();  // 2 cycles after acceptance -> RESP
        checks++;
        if ({rsp_valid, mem_write_enable, rsp_err} !== 3'b100 || rsp_rdata !== 32'd0) begin
            failures++; $display("FAIL write_resp valid/we/err=%b rdata=%0h required 100/0", {rsp_valid, mem_write_enable, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL write_handshake valid=%0h ready=%0h required 0/1", rsp_valid, req_ready);
        end
        checks++;
        if (mem_address !== 32'h10) begin failures++; $display("FAIL write_addr_hold actual=%0h required=10", mem_address); end
    endtask

    // Read with RD_LAT=3, then stall the response for 5 cycles.
    task automatic test_read(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_read_data = data;
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_read_enable, mem_write_enable, rsp_valid, req_ready} !== 4'b1000) begin
                failures++; $display("FAIL read_cycle%0d actual=%b required=1000", i, {mem_read_enable, mem_write_enable, rsp_valid, req_ready});
            end
            if (i == 1) begin
                // Request inputs must be ignored while busy.
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
            end
            step();
        end
        req_valid = 1'b0;
        mem_read_data = ~data;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== data || rsp_err !== 1'b0) begin
            failures++; $display("FAIL read_resp valid=%0h rdata=%0h err=%0h required 1/%0h/0", rsp_valid, rsp_rdata, rsp_err, data);
        end
        checks++;
        if (mem_address !== addr) begin failures++; $display("FAIL read_addr actual=%0h required=%0h", mem_address, addr); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== data || req_ready !== 1'b0 ||
                mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
                failures++; $display("FAIL stall%0d valid=%0h rdata=%0h ready=%0h re=%0h we=%0h required 1/%0h/0/0/0",
                                     i, rsp_valid, rsp_rdata, req_ready, mem_read_enable, mem_write_enable, data);
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL read_handshake valid=%0h ready=%0h required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_misaligned();
`ifdef CACHE_ACCESS_CTRL_ALIGN_CHECK_EN
        mem_read_data = 32'h5555_AAAA;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h13;
        step();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, mem_read_enable, mem_write_enable} !== 4'b1100 || rsp_rdata !== 32'd0) begin
            failures++; $display("FAIL misaligned_resp valid/err/re/we=%b rdata=%0h required 1100/0",
                                 {rsp_valid, rsp_err, mem_read_enable, mem_write_enable}, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b1) begin
            failures++; $display("FAIL misaligned_hold err=%0h valid=%0h required 1/1", rsp_err, rsp_valid);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL misaligned_done ready=%0h required=1", req_ready); end
`else
        test_read(32'h13, 32'h0BAD_CAFE);
`endif
    endtask

    task automatic test_reset_mid();
        // Reset on the 2nd READ cycle.
        mem_read_data = 32'h1111_2222;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || {mem_read_enable, mem_write_enable, rsp_valid, req_ready} !== 4'b0001) begin
            failures++; $display("FAIL rst_mid_read state=%0d flags=%b required 0/0001",
                                 dbg_state, {mem_read_enable, mem_write_enable, rsp_valid, req_ready});
        end
        // Reset while a response is pending.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h77;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_address !== 32'd0) begin
            failures++; $display("FAIL rst_mid_resp valid=%0h ready=%0h addr=%0h required 0/1/0", rsp_valid, req_ready, mem_address);
        end
    endtask

    task automatic test_back_to_back();
        state_e exp_st[8];
        logic   exp_rdy[8];
        exp_st  = '{ST_IDLE, ST_WRITE, ST_RESP, ST_IDLE, ST_READ, ST_READ, ST_READ, ST_RESP};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        mem_read_data = 32'hA5A5_0F0F;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hBEEF_0001;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (dbg_state !== exp_st[c] || req_ready !== exp_rdy[c] || (mem_write_enable && mem_read_enable)) begin
                failures++; $display("FAIL b2b_cycle%0d state=%0d ready=%0h we=%0h re=%0h required %0d/%0h no-overlap",
                                     c, dbg_state, req_ready, mem_write_enable, mem_read_enable, exp_st[c], exp_rdy[c]);
            end
            if (c == 1) begin req_we = 1'b0; req_addr = 32'h34; end
            if (c == 7) req_valid = 1'b0;
            if (c < 7) step();
        end
        checks++;
        if (rsp_rdata !== 32'hA5A5_0F0F || mem_address !== 32'h34) begin
            failures++; $display("FAIL b2b_read rdata=%0h addr=%0h required a5a50f0f/34", rsp_rdata, mem_address);
        end
        step();
        rsp_ready = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_end state=%0d valid=%0h required 0/0", dbg_state, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(32'h10, 32'hCAFEF00D);
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
